multi_cycle_control: RTL and testbench
======================================

# multi_cycle_control

Multi-cycle sequencing controller for the RV32I core. It replaces the single-cycle opcode decoder when the core shares a single instruction/data memory port, and it drives a datapath with IR, MDR, A/B and ALUOut registers. A Moore-style FSM steps each instruction through fetch, decode, execute, memory and writeback. Every memory access waits on a ready handshake, with a wait-timeout fault.

## Interface
- TIMEOUT_CYCLES, 255: maximum consecutive wait cycles in a memory state before a fault; 0 disables the timeout.
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- OP_i  input  7  opcode from the IR (IR bits 6:0).
- Funct3_i  input  3  IR bits 14:12, used for branches only.
- Zero_i  input  1  ALU zero flag.
- Mem_Ready_i  input  1  memory completes the current access this cycle.
- PC_Write_o  output  1  load PC.
- PC_Src_o  output  1  PC source: 0 = ALU result, 1 = ALUOut register.
- IR_Write_o  output  1  load IR from memory read data.
- I_or_D_o  output  1  memory address source: 0 = PC, 1 = ALUOut.
- Mem_Read_o  output  1  memory read request.
- Mem_Write_o  output  1  memory write request.
- Reg_Write_o  output  1  register file write enable.
- Mem_to_Reg_o  output  2  writeback source: 00 = ALUOut, 01 = MDR, 10 = PC.
- ALU_Src_A_o  output  1  ALU A source: 0 = PC, 1 = A register.
- ALU_Src_B_o  output  2  ALU B source: 00 = B register, 01 = constant 4, 10 = immediate.
- ALU_Op_o  output  3  ALU operation class: 000 R, 001 I-logic, 010 LUI, 011 S address, 100 LW address, 101 ADD, 110 SUB.
- Retire_o  output  1  one-cycle pulse when an instruction completes.
- Fault_o  output  1  sticky fault (illegal opcode or memory timeout).
- State_o  output  4  current state encoding, for debug.

## Operation
- State encodings: FETCH=0, DECODE=1, EXEC_R=2, EXEC_I=3, EXEC_LUI=4, ADDR=5, MEM_RD=6, MEM_WR=7, WB_ALU=8, WB_MEM=9, BRANCH=10, JAL=11, FAULT=15.
- Every output not listed for a state is 0 in that state.
- FETCH:
  - Outputs: Mem_Read=1, I_or_D=0, ALU_Src_A=0, ALU_Src_B=01, ALU_Op=101.
  - When Mem_Ready_i=1: IR_Write=1, PC_Write=1, PC_Src=0, next state DECODE. Otherwise stay in FETCH.
- DECODE:
  - Outputs: ALU_Src_A=0, ALU_Src_B=10, ALU_Op=101. The branch/JAL target is latched into ALUOut.
  - Next state by OP_i: 0x33→EXEC_R; 0x13→EXEC_I; 0x37→EXEC_LUI; 0x03 or 0x23→ADDR; 0x63→BRANCH; 0x6F→JAL; any other value→FAULT.
- EXEC_R: ALU_Src_A=1, ALU_Src_B=00, ALU_Op=000. Next state WB_ALU.
- EXEC_I: ALU_Src_A=1, ALU_Src_B=10, ALU_Op=001. Next state WB_ALU.
- EXEC_LUI: ALU_Src_B=10, ALU_Op=010. Next state WB_ALU.
- ADDR: ALU_Src_A=1, ALU_Src_B=10, ALU_Op=100 for LW or 011 for SW. Next state MEM_RD for LW, MEM_WR for SW.
- MEM_RD: Mem_Read=1, I_or_D=1. When Mem_Ready_i=1, next state WB_MEM; otherwise stay.
- MEM_WR: Mem_Write=1, I_or_D=1. When Mem_Ready_i=1, Retire=1 and next state FETCH; otherwise stay.
- WB_ALU: Reg_Write=1, Mem_to_Reg=00, Retire=1. Next state FETCH.
- WB_MEM: Reg_Write=1, Mem_to_Reg=01, Retire=1. Next state FETCH.
- BRANCH:
  - Outputs: ALU_Src_A=1, ALU_Src_B=00, ALU_Op=110, PC_Src=1, Retire=1.
  - PC_Write=1 when (Funct3_i=000 and Zero_i) or (Funct3_i=001 and !Zero_i).
  - Any other Funct3_i value is not taken; this is not a fault.
  - Next state FETCH.
- JAL: PC_Write=1, PC_Src=1, Reg_Write=1, Mem_to_Reg=10 (PC already holds PC+4), Retire=1. Next state FETCH.
- FAULT: absorbing state; all strobes 0, Fault_o=1. Only reset leaves it.
- Wait counter:
  - 8 bits wide, cleared on entry to FETCH, MEM_RD or MEM_WR.
  - Increments each cycle Mem_Ready_i=0 in those states, saturating at 255.
  - When the count equals TIMEOUT_CYCLES (nonzero) and Mem_Ready_i=0, next state is FAULT. Mem_Ready_i=1 in that same cycle wins.

## Timing
- Reset: state=FETCH, wait counter=0, Fault_o=0. All outputs take the FETCH values with Mem_Ready_i treated as 0 until the first edge.
- Reset asserted mid-instruction aborts it immediately (asynchronous); no partial write strobe survives.
- Latency with zero wait states, FETCH through retire inclusive:
  - R, I, LUI: 4 cycles.
  - LW: 5 cycles.
  - SW: 4 cycles.
  - Branch and JAL: 3 cycles.
- Each memory wait cycle adds exactly 1 cycle.
- Handshake:
  - The request is held stable from state entry until the cycle Mem_Ready_i=1.
  - The request deasserts the cycle after that.
  - Mem_Ready_i is ignored outside memory states.
- Outputs are decoded from registered state, plus Mem_Ready_i/Zero_i/Funct3_i gating only on the strobes listed above.

## Test plan
- R-type 0x33 with Mem_Ready_i tied 1 → states 0,1,2,8,0. Retire_o pulses in cycle 4. Reg_Write_o=1 only in cycle 4.
- LW 0x03 with 2 wait cycles in FETCH and 3 in MEM_RD → Mem_Read_o held 3 and 4 cycles respectively. WB_MEM has Mem_to_Reg_o=01. Total 10 cycles.
- BEQ with Zero_i=1 → PC_Write_o=1, PC_Src_o=1 in BRANCH. BNE with Zero_i=1 → PC_Write_o=0. Funct3_i=100 → not taken, no fault.
- JAL 0x6F → PC_Write_o, Reg_Write_o and Mem_to_Reg_o=10 together in cycle 3, then FETCH.
- Opcode 0x7F → FAULT after DECODE. Fault_o stays 1 for 100 cycles. Reset returns to FETCH with Fault_o=0.
- TIMEOUT_CYCLES=4 with Mem_Ready_i=0 in MEM_WR → FAULT after exactly 5 MEM_WR cycles. Mem_Ready_i=1 on the 5th cycle → retire instead. Reset asserted during MEM_WR → Mem_Write_o=0 immediately.

Source files
------------

// File: rtl/multi_cycle_control.sv
// multi_cycle_control: Moore sequencer stepping RV32I instructions through a shared-memory multi-cycle datapath
module multi_cycle_control #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] OP_i,
    input  logic [2:0] Funct3_i,
    input  logic       Zero_i,
    input  logic       Mem_Ready_i,
    output logic       PC_Write_o,
    output logic       PC_Src_o,
    output logic       IR_Write_o,
    output logic       I_or_D_o,
    output logic       Mem_Read_o,
    output logic       Mem_Write_o,
    output logic       Reg_Write_o,
    output logic [1:0] Mem_to_Reg_o,
    output logic       ALU_Src_A_o,
    output logic [1:0] ALU_Src_B_o,
    output logic [2:0] ALU_Op_o,
    output logic       Retire_o,
    output logic       Fault_o,
    output logic [3:0] State_o
);
    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        EXEC_R   = 4'd2,
        EXEC_I   = 4'd3,
        EXEC_LUI = 4'd4,
        ADDR     = 4'd5,
        MEM_RD   = 4'd6,
        MEM_WR   = 4'd7,
        WB_ALU   = 4'd8,
        WB_MEM   = 4'd9,
        BRANCH   = 4'd10,
        JAL      = 4'd11,
        FAULT    = 4'd15
    } state_t;
    state_t     state_q, state_d;
    logic [7:0] wait_q, wait_d;
    logic       rdy, mem_st, timeout, taken, is_lw;
    // ready is forced low while reset is held so no strobe fires during reset
    assign rdy     = Mem_Ready_i & ~reset;
    assign mem_st  = (state_q == FETCH) || (state_q == MEM_RD) || (state_q == MEM_WR);
    assign timeout = (TIMEOUT_CYCLES != 0) && (wait_q == 8'(TIMEOUT_CYCLES)) && !rdy;
    assign taken   = ((Funct3_i == 3'b000) && Zero_i) || ((Funct3_i == 3'b001) && !Zero_i);
    assign is_lw   = (OP_i == 7'h03);
    assign Fault_o = (state_q == FAULT);
    assign State_o = state_q;
    // state and wait counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FETCH;
            wait_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end
    // next-state logic; ready wins over timeout in the same cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:    state_d = timeout ? FAULT : (rdy ? DECODE : FETCH);
            DECODE: begin
                case (OP_i)
                    7'h33:        state_d = EXEC_R;
                    7'h13:        state_d = EXEC_I;
                    7'h37:        state_d = EXEC_LUI;
                    7'h03, 7'h23: state_d = ADDR;
                    7'h63:        state_d = BRANCH;
                    7'h6F:        state_d = JAL;
                    default:      state_d = FAULT;
                endcase
            end
            EXEC_R, EXEC_I, EXEC_LUI: state_d = WB_ALU;
            ADDR:     state_d = is_lw ? MEM_RD : MEM_WR;
            MEM_RD:   state_d = timeout ? FAULT : (rdy ? WB_MEM : MEM_RD);
            MEM_WR:   state_d = timeout ? FAULT : (rdy ? FETCH : MEM_WR);
            WB_ALU, WB_MEM, BRANCH, JAL: state_d = FETCH;
            default:  state_d = FAULT;
        endcase
    end
    // wait counter clears on any state change, counts saturating wait cycles in memory states
    always_comb begin
        wait_d = wait_q;
        if (state_d != state_q) wait_d = 8'd0;
        else if (mem_st && !rdy && wait_q != 8'hFF) wait_d = wait_q + 8'd1;
    end
    // Moore output decode with ready/branch gating on the completing strobes
    always_comb begin
        PC_Write_o   = 1'b0;
        PC_Src_o     = 1'b0;
        IR_Write_o   = 1'b0;
        I_or_D_o     = 1'b0;
        Mem_Read_o   = 1'b0;
        Mem_Write_o  = 1'b0;
        Reg_Write_o  = 1'b0;
        Mem_to_Reg_o = 2'b00;
        ALU_Src_A_o  = 1'b0;
        ALU_Src_B_o  = 2'b00;
        ALU_Op_o     = 3'b000;
        Retire_o     = 1'b0;
        case (state_q)
            FETCH: begin
                Mem_Read_o  = 1'b1;
                ALU_Src_B_o = 2'b01;
                ALU_Op_o    = 3'b101;
                IR_Write_o  = rdy;
                PC_Write_o  = rdy;
            end
            DECODE: begin
                ALU_Src_B_o = 2'b10;
                ALU_Op_o    = 3'b101;
            end
            EXEC_R: begin
                ALU_Src_A_o = 1'b1;
                ALU_Op_o    = 3'b000;
            end
            EXEC_I: begin
                ALU_Src_A_o = 1'b1;
                ALU_Src_B_o = 2'b10;
                ALU_Op_o    = 3'b001;
            end
            EXEC_LUI: begin
                ALU_Src_B_o = 2'b10;
                ALU_Op_o    = 3'b010;
            end
            ADDR: begin
                ALU_Src_A_o = 1'b1;
                ALU_Src_B_o = 2'b10;
                ALU_Op_o    = is_lw ? 3'b100 : 3'b011;
            end
            MEM_RD: begin
                Mem_Read_o = 1'b1;
                I_or_D_o   = 1'b1;
            end
            MEM_WR: begin
                Mem_Write_o = 1'b1;
                I_or_D_o    = 1'b1;
                Retire_o    = rdy;
            end
            WB_ALU: begin
                Reg_Write_o = 1'b1;
                Retire_o    = 1'b1;
            end
            WB_MEM: begin
                Reg_Write_o  = 1'b1;
                Mem_to_Reg_o = 2'b01;
                Retire_o     = 1'b1;
            end
            BRANCH: begin
                ALU_Src_A_o = 1'b1;
                ALU_Op_o    = 3'b110;
                PC_Src_o    = 1'b1;
                PC_Write_o  = taken;
                Retire_o    = 1'b1;
            end
            JAL: begin
                PC_Write_o   = 1'b1;
                PC_Src_o     = 1'b1;
                Reg_Write_o  = 1'b1;
                Mem_to_Reg_o = 2'b10;
                Retire_o     = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_multi_cycle_control.sv
// tb_multi_cycle_control: directed and randomized instruction traces checked against a spec-level model
module tb_multi_cycle_control;
    localparam int TO = 4;
    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] OP_i;
    logic [2:0] Funct3_i;
    logic       Zero_i;
    logic       Mem_Ready_i;
    logic       PC_Write_o, PC_Src_o, IR_Write_o, I_or_D_o, Mem_Read_o, Mem_Write_o, Reg_Write_o;
    logic [1:0] Mem_to_Reg_o, ALU_Src_B_o;
    logic       ALU_Src_A_o, Retire_o, Fault_o;
    logic [2:0] ALU_Op_o;
    logic [3:0] State_o;
    int errors = 0;
    int checks = 0;
    logic [6:0] ops [8] = '{7'h33, 7'h13, 7'h37, 7'h03, 7'h23, 7'h63, 7'h63, 7'h6F};

    multi_cycle_control #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .OP_i(OP_i), .Funct3_i(Funct3_i), .Zero_i(Zero_i),
        .Mem_Ready_i(Mem_Ready_i), .PC_Write_o(PC_Write_o), .PC_Src_o(PC_Src_o),
        .IR_Write_o(IR_Write_o), .I_or_D_o(I_or_D_o), .Mem_Read_o(Mem_Read_o),
        .Mem_Write_o(Mem_Write_o), .Reg_Write_o(Reg_Write_o), .Mem_to_Reg_o(Mem_to_Reg_o),
        .ALU_Src_A_o(ALU_Src_A_o), .ALU_Src_B_o(ALU_Src_B_o), .ALU_Op_o(ALU_Op_o),
        .Retire_o(Retire_o), .Fault_o(Fault_o), .State_o(State_o)
    );

    always #5 clk = ~clk;

    wire [20:0] obs = {PC_Write_o, PC_Src_o, IR_Write_o, I_or_D_o, Mem_Read_o, Mem_Write_o,
                       Reg_Write_o, Mem_to_Reg_o, ALU_Src_A_o, ALU_Src_B_o, ALU_Op_o,
                       Retire_o, Fault_o, State_o};

    // output vector the control table requires for a given state and input conditions
    function automatic logic [20:0] exp_out(input logic [3:0] st, input logic rdy, input logic z,
                                            input logic [2:0] f3, input logic [6:0] op);
        logic pcw = 0, pcs = 0, irw = 0, iod = 0, mr = 0, mw = 0, rw = 0, asa = 0, ret = 0, flt = 0;
        logic [1:0] m2r = 0, asb = 0;
        logic [2:0] aop = 0;
        case (st)
            4'd0:  begin mr = 1; asb = 1; aop = 5; irw = rdy; pcw = rdy; end
            4'd1:  begin asb = 2; aop = 5; end
            4'd2:  begin asa = 1; aop = 0; end
            4'd3:  begin asa = 1; asb = 2; aop = 1; end
            4'd4:  begin asb = 2; aop = 2; end
            4'd5:  begin asa = 1; asb = 2; aop = (op == 7'h03) ? 3'd4 : 3'd3; end
            4'd6:  begin mr = 1; iod = 1; end
            4'd7:  begin mw = 1; iod = 1; ret = rdy; end
            4'd8:  begin rw = 1; ret = 1; end
            4'd9:  begin rw = 1; m2r = 1; ret = 1; end
            4'd10: begin asa = 1; aop = 6; pcs = 1; ret = 1; pcw = (f3 == 3'd0 && z) || (f3 == 3'd1 && !z); end
            4'd11: begin pcw = 1; pcs = 1; rw = 1; m2r = 2; ret = 1; end
            4'd15: flt = 1;
            default: ;
        endcase
        return {pcw, pcs, irw, iod, mr, mw, rw, m2r, asa, asb, aop, ret, flt, st};
    endfunction

    task automatic chk(input string tag, input logic [20:0] o, input logic [20:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    // one clock cycle: drive ready mid-low-phase, then compare all outputs with the expected state
    task automatic step(input logic rdy, input logic [3:0] st, input string tag);
        @(negedge clk);
        Mem_Ready_i = rdy;
        #1 chk(tag, obs, exp_out(st, rdy, Zero_i, Funct3_i, OP_i));
    endtask

    // instruction-level model: the state path an instruction takes given its class and wait counts
    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic z, input int wf, input int wm);
        OP_i = op; Funct3_i = f3; Zero_i = z;
        for (int i = 0; i < wf; i++) step(1'b0, 4'd0, "fetch_wait");
        step(1'b1, 4'd0, "fetch");
        step(1'($urandom), 4'd1, "decode");
        case (op)
            7'h33: begin step(1'($urandom), 4'd2, "exec_r"); step(1'($urandom), 4'd8, "wb_alu"); end
            7'h13: begin step(1'($urandom), 4'd3, "exec_i"); step(1'($urandom), 4'd8, "wb_alu"); end
            7'h37: begin step(1'($urandom), 4'd4, "exec_lui"); step(1'($urandom), 4'd8, "wb_alu"); end
            7'h03: begin
                step(1'($urandom), 4'd5, "addr_lw");
                for (int i = 0; i < wm; i++) step(1'b0, 4'd6, "mem_rd_wait");
                step(1'b1, 4'd6, "mem_rd");
                step(1'($urandom), 4'd9, "wb_mem");
            end
            7'h23: begin
                step(1'($urandom), 4'd5, "addr_sw");
                for (int i = 0; i < wm; i++) step(1'b0, 4'd7, "mem_wr_wait");
                step(1'b1, 4'd7, "mem_wr");
            end
            7'h63: step(1'($urandom), 4'd10, "branch");
            7'h6F: step(1'($urandom), 4'd11, "jal");
            default: step(1'($urandom), 4'd15, "fault");
        endcase
    endtask

    task automatic sw_prefix();
        OP_i = 7'h23;
        step(1'b1, 4'd0, "sw_fetch");
        step(1'($urandom), 4'd1, "sw_decode");
        step(1'($urandom), 4'd5, "sw_addr");
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 reset = 1'b1;
        Mem_Ready_i = 1'b1;
        #1 chk("reset_state", obs, exp_out(4'd0, 1'b0, Zero_i, Funct3_i, OP_i));
        @(negedge clk);
        Mem_Ready_i = 1'b0;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; OP_i = 7'h33; Funct3_i = 3'd0; Zero_i = 1'b0; Mem_Ready_i = 1'b1;
        #3 chk("reset_state", obs, exp_out(4'd0, 1'b0, Zero_i, Funct3_i, OP_i));
        @(negedge clk);
        Mem_Ready_i = 1'b0;
        reset = 1'b0;
        run_instr(7'h33, 3'd0, 1'b0, 0, 0);
        run_instr(7'h03, 3'd2, 1'b0, 2, 3);
        run_instr(7'h63, 3'd0, 1'b1, 0, 0);
        run_instr(7'h63, 3'd1, 1'b1, 0, 0);
        run_instr(7'h63, 3'd1, 1'b0, 1, 0);
        run_instr(7'h63, 3'd4, 1'b1, 0, 0);
        run_instr(7'h6F, 3'd0, 1'b0, 0, 0);
        run_instr(7'h23, 3'd0, 1'b0, 1, 2);
        for (int n = 0; n < 60; n++)
            run_instr(ops[$urandom_range(0, 7)], 3'($urandom), 1'($urandom),
                      $urandom_range(0, TO - 1), $urandom_range(0, TO - 1));
        sw_prefix();
        for (int i = 0; i < TO; i++) step(1'b0, 4'd7, "to_wait");
        step(1'b1, 4'd7, "to_ready_wins");
        step(1'b0, 4'd0, "to_back_fetch");
        OP_i = 7'h33;
        step(1'b1, 4'd0, "fetch");
        step(1'b0, 4'd1, "decode");
        step(1'b0, 4'd2, "exec_r");
        step(1'b0, 4'd8, "wb_alu");
        sw_prefix();
        for (int i = 0; i <= TO; i++) step(1'b0, 4'd7, "to_wait");
        step(1'b0, 4'd15, "to_fault");
        do_reset();
        sw_prefix();
        step(1'b0, 4'd7, "mem_wr_before_reset");
        #2 reset = 1'b1;
        #1 chk("reset_mid_write", obs, exp_out(4'd0, 1'b0, Zero_i, Funct3_i, OP_i));
        @(negedge clk);
        reset = 1'b0;
        run_instr(7'h7F, 3'd0, 1'b0, 0, 0);
        for (int i = 0; i < 100; i++) step(1'($urandom), 4'd15, "fault_sticky");
        do_reset();
        run_instr(7'h13, 3'd0, 1'b0, 0, 0);
        run_instr(7'h37, 3'd0, 1'b0, 0, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
